// File: rtl/ay_pkg.sv
// Shared constants and types for the AY-3-8910 style PSG blocks.
package ay_pkg;

  localparam int unsigned SHAPE_HOLD = 0;
  localparam int unsigned SHAPE_ALT  = 1;
  localparam int unsigned SHAPE_ATT  = 2;
  localparam int unsigned SHAPE_CONT = 3;

  localparam int unsigned AMP_W = 4;
  localparam logic [AMP_W-1:0] AMP_MAX = 4'hF;

  typedef enum logic {
    ENV_RUN  = 1'b0,
    ENV_HOLD = 1'b1
  } env_state_e;

  function automatic logic [AMP_W-1:0] env_level(input logic [AMP_W-1:0] step,
                                                 input logic inv);
    return step ^ {AMP_W{inv}};
  endfunction

endpackage

// File: rtl/ay_period_div.sv
// Tick-rate period divider shared by the tone, noise and envelope generators.
// A period of 0 behaves as 1; a period shrunk below the count fires on the next tick.
module ay_period_div #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  input  logic                enable,
  output logic                strobe
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] limit;
  logic                hit;
  logic                advance;

  always_comb begin
    limit = '0;
    if (period != '0) limit = period - PERIOD_W'(1);
  end

  assign hit     = (cnt >= limit);
  assign advance = tick & enable & ~clear;
  assign strobe  = advance & hit;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= hit ? '0 : cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/ay_envelope.sv
// AY-3-8910 style envelope generator: 16-level ramp shaped by CONT/ATT/ALT/HOLD,
// stepped once per period of base-rate ticks.
module ay_envelope
  import ay_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          shape,
  input  logic                shape_wr,
  output logic [AMP_W-1:0]    amp,
  output logic                holding
);

  env_state_e       state, state_nxt;
  logic [3:0]       shp, shp_nxt;
  logic [AMP_W-1:0] step, step_nxt;
  logic             inv, inv_nxt;
  logic             step_evt;

  ay_period_div #(
    .PERIOD_W (PERIOD_W)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .clear  (shape_wr),
    .period (period),
    .enable (state == ENV_RUN),
    .strobe (step_evt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ENV_HOLD;
      shp   <= '0;
      step  <= AMP_MAX;
      inv   <= 1'b1;
    end else begin
      state <= state_nxt;
      shp   <= shp_nxt;
      step  <= step_nxt;
      inv   <= inv_nxt;
    end
  end

  // The divider suppresses step_evt on a shape write, so a coincident tick is lost.
  always_comb begin
    state_nxt = state;
    shp_nxt   = shp;
    step_nxt  = step;
    inv_nxt   = inv;
    if (shape_wr) begin
      state_nxt = ENV_RUN;
      shp_nxt   = shape;
      step_nxt  = '0;
      inv_nxt   = ~shape[SHAPE_ATT];
    end else if (step_evt) begin
      if (step != AMP_MAX) begin
        step_nxt = step + AMP_W'(1);
      end else if (!shp[SHAPE_CONT]) begin
        state_nxt = ENV_HOLD;
        inv_nxt   = 1'b1;
      end else if (shp[SHAPE_HOLD]) begin
        state_nxt = ENV_HOLD;
        inv_nxt   = inv ^ shp[SHAPE_ALT];
      end else begin
        step_nxt = '0;
        inv_nxt  = inv ^ shp[SHAPE_ALT];
      end
    end
  end

  assign amp     = env_level(step, inv);
  assign holding = (state == ENV_HOLD);

endmodule

// File: tb/tb_ay_envelope.sv
// Self-checking bench for ay_envelope: directed shape scenarios plus random
// traffic, compared against a step-count based model of the envelope.
module tb_ay_envelope;

  localparam int unsigned PERIOD_W = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                tick = 1'b0;
  logic [PERIOD_W-1:0] period = 16'd1;
  logic [3:0]          shape = 4'h0;
  logic                shape_wr = 1'b0;
  logic [3:0]          amp;
  logic                holding;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Model: shape, number of completed steps since restart, divider count.
  logic [3:0]  m_shp = 4'h0;
  int unsigned m_n   = 16;
  int unsigned m_cnt = 0;

  ay_envelope #(.PERIOD_W(PERIOD_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .period   (period),
    .shape    (shape),
    .shape_wr (shape_wr),
    .amp      (amp),
    .holding  (holding)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_frozen();
    return (m_n >= 16) && (!m_shp[3] || m_shp[0]);
  endfunction

  function automatic int unsigned ref_amp();
    int unsigned pos;
    int unsigned k;
    bit up;
    if (m_n < 16) begin
      pos = m_n;
      up  = m_shp[2];
    end else if (!m_shp[3]) begin
      return 0;
    end else if (m_shp[0]) begin
      return (m_shp[2] ^ m_shp[1]) ? 15 : 0;
    end else begin
      k   = m_n / 16;
      pos = m_n % 16;
      up  = m_shp[2] ^ (m_shp[1] & k[0]);
    end
    return up ? pos : 15 - pos;
  endfunction

  task automatic model_edge(input bit r, input bit t, input bit sw, input logic [3:0] sh,
                            input int unsigned per);
    int unsigned lim;
    lim = (per == 0) ? 1 : per;
    if (r) begin
      m_shp = 4'h0;
      m_n   = 16;
      m_cnt = 0;
    end else if (sw) begin
      m_shp = sh;
      m_n   = 0;
      m_cnt = 0;
    end else if (t && !ref_frozen()) begin
      if (m_cnt + 1 >= lim) begin
        m_cnt = 0;
        m_n++;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic cycle(input string tag, input bit r, input bit t, input bit sw,
                       input logic [3:0] sh);
    reset    = r;
    tick     = t;
    shape_wr = sw;
    shape    = sh;
    @(posedge clk);
    model_edge(r, t, sw, sh, int'(period));
    #1;
    check_eq({tag, ".amp"}, int'(amp), ref_amp());
    check_eq({tag, ".holding"}, int'(holding), int'(ref_frozen()));
  endtask

  task automatic run_ticks(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(tag, 1'b0, 1'b1, 1'b0, shape);
  endtask

  initial begin
    // Reset with ticks present, then ticks must not disturb the hold.
    period = 16'd1;
    cycle("reset", 1'b1, 1'b1, 1'b0, 4'h0);
    cycle("reset", 1'b1, 1'b1, 1'b0, 4'h0);
    run_ticks("post_reset", 5);

    cycle("decay_wr", 1'b0, 1'b0, 1'b1, 4'h0);
    run_ticks("decay", 24);

    period = 16'd2;
    cycle("tri_wr", 1'b0, 1'b0, 1'b1, 4'hE);
    run_ticks("triangle", 140);

    period = 16'd1;
    cycle("atk_hold_wr", 1'b0, 1'b0, 1'b1, 4'hD);
    run_ticks("atk_hold", 24);
    cycle("alt_hold_wr", 1'b0, 1'b0, 1'b1, 4'hB);
    run_ticks("alt_hold", 24);

    period = 16'd0;
    cycle("p0_wr", 1'b0, 1'b0, 1'b1, 4'h0);
    run_ticks("period0", 20);

    // Shrink the period below the running count.
    period = 16'd100;
    cycle("shrink_wr", 1'b0, 1'b0, 1'b1, 4'h8);
    run_ticks("p100", 50);
    period = 16'd3;
    run_ticks("p3", 12);

    // Restart and tick together mid-ramp, then reset mid-ramp.
    period = 16'd1;
    cycle("coll_wr", 1'b0, 1'b0, 1'b1, 4'hC);
    run_ticks("coll_pre", 6);
    cycle("coll", 1'b0, 1'b1, 1'b1, 4'hC);
    run_ticks("coll_post", 4);
    cycle("mid_reset", 1'b1, 1'b1, 1'b0, 4'hC);
    run_ticks("after_reset", 4);

    for (int unsigned i = 0; i < 4000; i++) begin
      bit r, t, sw;
      if ($urandom_range(0, 99) < 3) period = PERIOD_W'($urandom_range(0, 5));
      r  = ($urandom_range(0, 499) == 0);
      sw = ($urandom_range(0, 99) < 2);
      t  = ($urandom_range(0, 3) != 0);
      cycle("random", r, t, sw, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
